melody_sequencer: RTL and testbench

//  Sequencer that drives the organ's tone generator.
//  - Plays a fixed 16-entry song table note by note, with a configurable beat tempo and a silent gap between notes.
//  - Manual keys (do..si) take priority over the song and freeze its timing while held.
//  - Outputs: note code plus half-period count (period) for the tone divider; busy/done status.

---
 rtl/melody_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_melody_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// melody_sequencer : song-table player with manual-key override for the organ
// Rev 1.0
// ============================================================================
module melody_sequencer #(
  parameter int TICK_DIV  = 12_500_000,
  parameter int GAP_TICKS = 1,
  parameter int SONG_LEN  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [6:0]  key,
  output logic [2:0]  note,
  output logic [14:0] period,
  output logic        busy,
  output logic        done,
  output logic [3:0]  song_idx
);

  localparam int TCW = $clog2(TICK_DIV);
  localparam int GCW = $clog2(GAP_TICKS + 1);
  localparam logic [TCW-1:0] C_TICK_MAX = TCW'(TICK_DIV - 1);
  localparam logic [GCW-1:0] C_GAP_INIT = GCW'(GAP_TICKS);
  localparam logic [3:0]     C_LAST_IDX = 4'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_NOTE   = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  function automatic logic [14:0] f_period(input logic [2:0] n);
    case (n)
      3'd1:    f_period = 15'd19120;
      3'd2:    f_period = 15'd17036;
      3'd3:    f_period = 15'd15175;
      3'd4:    f_period = 15'd14327;
      3'd5:    f_period = 15'd12755;
      3'd6:    f_period = 15'd11364;
      3'd7:    f_period = 15'd10121;
      default: f_period = 15'd0;
    endcase
  endfunction

  // Entry = {note, beats}; beats == 0 marks the end of the song.
  function automatic logic [5:0] f_song(input logic [3:0] i);
    case (i)
      4'd0, 4'd1:   f_song = {3'd1, 3'd1};
      4'd2, 4'd3:   f_song = {3'd5, 3'd1};
      4'd4, 4'd5:   f_song = {3'd6, 3'd1};
      4'd6:         f_song = {3'd5, 3'd2};
      4'd7, 4'd8:   f_song = {3'd4, 3'd1};
      4'd9, 4'd10:  f_song = {3'd3, 3'd1};
      4'd11, 4'd12: f_song = {3'd2, 3'd1};
      4'd13:        f_song = {3'd1, 3'd2};
      default:      f_song = 6'd0;
    endcase
  endfunction

  state_t             r_state;
  logic [TCW-1:0]     r_tick_cnt;
  logic [2:0]         r_beats;
  logic [GCW-1:0]     r_gap;
  logic [3:0]         r_idx;
  logic [2:0]         r_song_note;
  logic [2:0]         r_note;
  logic [14:0]        r_period;
  logic               r_busy;
  logic               r_done;

  logic [2:0]         w_key_note;
  logic               w_key_any;
  logic               w_counting;
  logic               w_tick;
  logic [5:0]         w_entry;

  always_comb begin
    w_key_note = 3'd0;
    for (int b = 6; b >= 0; b--) begin
      if (key[b]) w_key_note = 3'(b + 1);
    end
  end

  assign w_key_any  = |key;
  assign w_counting = ((r_state == S_NOTE) || (r_state == S_GAP)) && !w_key_any;
  assign w_tick     = w_counting && (r_tick_cnt == C_TICK_MAX);
  assign w_entry    = f_song(r_idx);

  always_ff @(posedge clk) begin
    if (reset || stop || (r_state == S_LOAD)) begin
      r_tick_cnt <= '0;
    end else if (w_counting) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TCW'(1);
    end
  end

  // A held key freezes every transition; only stop and reset break through.
  always_ff @(posedge clk) begin
    if (reset || stop) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_song_note <= 3'd0;
      r_note      <= 3'd0;
      r_period    <= 15'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_beats     <= 3'd0;
      r_gap       <= '0;
    end else if (w_key_any) begin
      r_note   <= w_key_note;
      r_period <= f_period(w_key_note);
      r_done   <= 1'b0;
    end else begin
      r_note   <= r_song_note;
      r_period <= f_period(r_song_note);
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_idx   <= 4'd0;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_entry[2:0] == 3'd0) begin
            r_state <= S_FINISH;
            r_busy  <= 1'b0;
            r_idx   <= 4'd0;
            r_done  <= 1'b1;
          end else begin
            r_state     <= S_NOTE;
            r_song_note <= w_entry[5:3];
            r_note      <= w_entry[5:3];
            r_period    <= f_period(w_entry[5:3]);
            r_beats     <= w_entry[2:0];
          end
        end
        S_NOTE: begin
          if (w_tick) begin
            if (r_beats == 3'd1) begin
              r_state     <= S_GAP;
              r_song_note <= 3'd0;
              r_note      <= 3'd0;
              r_period    <= 15'd0;
              r_gap       <= C_GAP_INIT;
            end
            r_beats <= r_beats - 3'd1;
          end
        end
        S_GAP: begin
          if (w_tick) begin
            if (r_gap == GCW'(1)) begin
              if (r_idx == C_LAST_IDX) begin
                r_state <= S_FINISH;
                r_busy  <= 1'b0;
                r_idx   <= 4'd0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_LOAD;
                r_idx   <= r_idx + 4'd1;
              end
            end
            r_gap <= r_gap - GCW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign note     = r_note;
  assign period   = r_period;
  assign busy     = r_busy;
  assign done     = r_done;
  assign song_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
// tb_melody_sequencer : directed + random stimulus against a segment-timer model
// Rev 1.0
// ============================================================================
module tb_melody_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;

  localparam int P_IDLE = 0, P_LOAD = 1, P_NOTE = 2, P_GAP = 3, P_FIN = 4;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [6:0]  key;
  logic [2:0]  note;
  logic [14:0] period;
  logic        busy, done;
  logic [3:0]  song_idx;

  always #5 clk = ~clk;

  melody_sequencer #(
    .TICK_DIV (TICK_DIV),
    .GAP_TICKS(GAP_TICKS),
    .SONG_LEN (16)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .key     (key),
    .note    (note),
    .period  (period),
    .busy    (busy),
    .done    (done),
    .song_idx(song_idx)
  );

  int song_notes [16] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1, 0, 0};
  int song_beats [16] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2, 0, 0};
  int ptab       [8]  = '{0, 19120, 17036, 15175, 14327, 12755, 11364, 10121};

  // Model: each song phase is a budget of unfrozen cycles that drains to zero.
  int m_phase = P_IDLE, m_idx = 0, m_rem = 0, m_song = 0;
  int e_note = 0, e_busy = 0, e_done = 0;

  int n_cmp = 0, n_bad = 0, n_done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest_key(input logic [6:0] k);
    for (int b = 0; b < 7; b++) if (k[b]) return b + 1;
    return 0;
  endfunction

  task automatic finish_song();
    m_phase = P_FIN;
    e_busy  = 0;
    m_idx   = 0;
    e_done  = 1;
  endtask

  task automatic model_step(input bit r, input bit s, input bit p, input logic [6:0] k);
    if (r || p) begin
      m_phase = P_IDLE; m_idx = 0; m_rem = 0; m_song = 0;
      e_note = 0; e_busy = 0; e_done = 0;
    end else if (k != 7'd0) begin
      e_note = lowest_key(k);
      e_done = 0;
    end else begin
      e_done = 0;
      case (m_phase)
        P_IDLE: if (s) begin m_phase = P_LOAD; m_idx = 0; e_busy = 1; end
        P_LOAD: begin
          if (song_beats[m_idx] == 0) finish_song();
          else begin
            m_phase = P_NOTE;
            m_song  = song_notes[m_idx];
            m_rem   = song_beats[m_idx] * TICK_DIV;
          end
        end
        P_NOTE: begin
          m_rem--;
          if (m_rem == 0) begin m_phase = P_GAP; m_song = 0; m_rem = GAP_TICKS * TICK_DIV; end
        end
        P_GAP: begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_idx == 15) finish_song();
            else begin m_idx++; m_phase = P_LOAD; end
          end
        end
        default: m_phase = P_IDLE;
      endcase
      e_note = m_song;
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit p, input logic [6:0] k);
    reset = r; start = s; stop = p; key = k;
    model_step(r, s, p, k);
    @(posedge clk);
    #1;
    check("note",     32'(note),     32'(e_note));
    check("period",   32'(period),   32'(ptab[e_note]));
    check("busy",     32'(busy),     32'(e_busy));
    check("done",     32'(done),     32'(e_done));
    check("song_idx", 32'(song_idx), 32'(m_idx));
    if (done === 1'b1) n_done_seen++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 7'd0);
  endtask

  initial begin
    int burst_left;
    logic [6:0] burst_key;
    burst_left = 0;
    burst_key  = 7'd0;

    cycle(1, 0, 0, 7'd0);
    cycle(1, 0, 0, 7'd0);

    // Reset held two cycles in the middle of a song
    cycle(0, 1, 0, 7'd0);
    idle_cycles(40);
    cycle(1, 0, 0, 7'd0);
    cycle(1, 0, 0, 7'd0);

    // Uninterrupted song from a single start pulse
    n_done_seen = 0;
    cycle(0, 1, 0, 7'd0);
    idle_cycles(200);
    check("done_count", 32'(n_done_seen), 32'd1);

    // Stop during idx2, then restart
    cycle(0, 1, 0, 7'd0);
    idle_cycles(20);
    cycle(0, 0, 1, 7'd0);
    cycle(0, 1, 0, 7'd0);
    idle_cycles(12);
    cycle(0, 0, 1, 7'd0);

    // start+stop together in IDLE, then start while busy
    cycle(0, 1, 1, 7'd0);
    cycle(0, 0, 0, 7'd0);
    cycle(0, 1, 0, 7'd0);
    idle_cycles(10);
    cycle(0, 1, 0, 7'd0);
    idle_cycles(10);
    cycle(0, 0, 1, 7'd0);

    // Keys in IDLE, multi-key priority
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 7'b1000001);
    idle_cycles(2);

    // Key held during idx0 after one tick count has elapsed
    cycle(0, 1, 0, 7'd0);
    cycle(0, 0, 0, 7'd0);
    cycle(0, 0, 0, 7'd0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 7'b0010000);
    idle_cycles(20);
    cycle(0, 0, 1, 7'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, s, p;
      r = ($urandom_range(0, 999) == 0);
      p = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 15) == 0);
      if (burst_left == 0 && $urandom_range(0, 39) == 0) begin
        burst_left = $urandom_range(1, 12);
        burst_key  = 7'($urandom_range(1, 127));
      end
      if (burst_left > 0) begin
        burst_left--;
        cycle(r, s, p, burst_key);
      end else begin
        cycle(r, s, p, 7'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
